// File: rtl/peri_bridge_pkg.sv
// rtl/peri_bridge_pkg.sv - shared FSM state type and CSR offsets for the peripheral bridge
package peri_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int CSR_STATUS  = 0;
    localparam int CSR_ERRADDR = 1;

endpackage

// File: rtl/peri_bridge_if.sv
// rtl/peri_bridge_if.sv - CPU-side and slave-side bus signals of the peripheral bridge
interface peri_bridge_if #(
    parameter int N_SLV  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);

    logic [ADDR_W-1:0]       cpu_addr;
    logic [DATA_W-1:0]       cpu_wdata;
    logic [DATA_W-1:0]       cpu_rdata;
    logic                    cpu_wr_en;
    logic                    cpu_rd_en;
    logic                    cpu_ready;
    logic [ADDR_W-1:0]       slv_addr;
    logic [DATA_W-1:0]       slv_wdata;
    logic [N_SLV-1:0]        slv_wr_en;
    logic [N_SLV-1:0]        slv_rd_en;
    logic [N_SLV*DATA_W-1:0] slv_rdata;
    logic [N_SLV-1:0]        slv_ready;

    // master: the CPU plus the peripherals around the bridge
    modport master (
        output cpu_addr, cpu_wdata, cpu_wr_en, cpu_rd_en, slv_rdata, slv_ready,
        input  cpu_rdata, cpu_ready, slv_addr, slv_wdata, slv_wr_en, slv_rd_en
    );

    // slave: the bridge itself
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wr_en, cpu_rd_en, slv_rdata, slv_ready,
        output cpu_rdata, cpu_ready, slv_addr, slv_wdata, slv_wr_en, slv_rd_en
    );

endinterface

// File: rtl/peri_decode.sv
// rtl/peri_decode.sv - combinational address decode: one-hot slave select, CSR hit, unmapped flag
module peri_decode
    import peri_bridge_pkg::*;
#(
    parameter int                      N_SLV    = 4,
    parameter int                      ADDR_W   = 8,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {8'h90, 8'h84, 8'h80, 8'h00},
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = {8'hFC, 8'hFC, 8'hFC, 8'h80},
    parameter logic [ADDR_W-1:0]       CSR_BASE = 8'hFC
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [N_SLV-1:0]  sel,
    output logic              csr_hit,
    output logic              unmapped
);

    localparam logic [ADDR_W-1:0] STATUS_ADDR  = CSR_BASE + ADDR_W'(CSR_STATUS);
    localparam logic [ADDR_W-1:0] ERRADDR_ADDR = CSR_BASE + ADDR_W'(CSR_ERRADDR);

    logic slave_hit;

    always_comb begin
        sel       = '0;
        slave_hit = 1'b0;
        csr_hit   = (addr == STATUS_ADDR) || (addr == ERRADDR_ADDR);
        // lowest matching index wins; CSR addresses shadow every slave window
        for (int i = 0; i < N_SLV; i++) begin
            if (!slave_hit && ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
                sel[i]    = 1'b1;
                slave_hit = 1'b1;
            end
        end
        if (csr_hit) begin
            sel = '0;
        end
        unmapped = !csr_hit && !slave_hit;
    end

endmodule

// File: rtl/peri_bridge.sv
// rtl/peri_bridge.sv - CPU-to-peripheral bridge with address decode, wait timeout and error CSRs
module peri_bridge
    import peri_bridge_pkg::*;
#(
    parameter int                      N_SLV    = 4,
    parameter int                      DATA_W   = 8,
    parameter int                      ADDR_W   = 8,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {8'h90, 8'h84, 8'h80, 8'h00},
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = {8'hFC, 8'hFC, 8'hFC, 8'h80},
    parameter int                      TIMEOUT  = 15,
    parameter logic [ADDR_W-1:0]       CSR_BASE = 8'hFC,
    parameter logic [DATA_W-1:0]       ERR_DATA = 8'hFF
) (
    input  logic         clk,
    input  logic         reset,
    peri_bridge_if.slave bus,
    output logic         err_irq
);

    localparam int                CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] STATUS_ADDR = CSR_BASE + ADDR_W'(CSR_STATUS);

    state_t              state, state_nxt;
    logic [N_SLV-1:0]    dec_sel;
    logic                dec_csr, dec_unmapped;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                is_wr_q;
    logic [N_SLV-1:0]    sel_q;
    logic [CNT_W-1:0]    wait_cnt;
    logic [DATA_W-1:0]   rdata_q, rdata_nxt;
    logic                rdata_ld;
    logic [1:0]          status_q, status_set, status_clr;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_nxt;
    logic                err_ld;
    logic                accept, ready_hit, timed_out;
    logic [DATA_W-1:0]   sel_rdata;

    peri_decode #(
        .N_SLV    (N_SLV),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK),
        .CSR_BASE (CSR_BASE)
    ) u_decode (
        .addr     (bus.cpu_addr),
        .sel      (dec_sel),
        .csr_hit  (dec_csr),
        .unmapped (dec_unmapped)
    );

    always_comb begin
        state_nxt    = state;
        accept       = (state == ST_IDLE) && (bus.cpu_wr_en || bus.cpu_rd_en);
        ready_hit    = |(bus.slv_ready & sel_q);
        timed_out    = (wait_cnt == CNT_W'(TIMEOUT - 1)) && !ready_hit;
        rdata_ld     = 1'b0;
        rdata_nxt    = rdata_q;
        status_set   = 2'b00;
        status_clr   = 2'b00;
        err_ld       = 1'b0;
        err_addr_nxt = err_addr_q;
        sel_rdata    = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | bus.slv_rdata[i*DATA_W +: DATA_W];
            end
        end

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (|dec_sel) ? ST_ACCESS : ST_RESP;
                end
                // CSR and unmapped accesses resolve entirely on the accept edge
                if (accept && dec_unmapped) begin
                    status_set[1] = 1'b1;
                    err_ld        = 1'b1;
                    err_addr_nxt  = bus.cpu_addr;
                    if (!bus.cpu_wr_en) begin
                        rdata_ld  = 1'b1;
                        rdata_nxt = '0;
                    end
                end
                if (accept && dec_csr) begin
                    if (bus.cpu_wr_en) begin
                        if (bus.cpu_addr == STATUS_ADDR) begin
                            status_clr = bus.cpu_wdata[1:0];
                        end
                    end else begin
                        rdata_ld  = 1'b1;
                        rdata_nxt = (bus.cpu_addr == STATUS_ADDR) ? DATA_W'(status_q) : DATA_W'(err_addr_q);
                    end
                end
            end
            ST_ACCESS: begin
                if (ready_hit || timed_out) begin
                    state_nxt = ST_RESP;
                end
                if (ready_hit && !is_wr_q) begin
                    rdata_ld  = 1'b1;
                    rdata_nxt = sel_rdata;
                end
                if (timed_out) begin
                    status_set[0] = 1'b1;
                    err_ld        = 1'b1;
                    err_addr_nxt  = addr_q;
                    if (!is_wr_q) begin
                        rdata_ld  = 1'b1;
                        rdata_nxt = ERR_DATA;
                    end
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            sel_q      <= '0;
            wait_cnt   <= '0;
            rdata_q    <= '0;
            status_q   <= 2'b00;
            err_addr_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= bus.cpu_addr;
                wdata_q <= bus.cpu_wdata;
                is_wr_q <= bus.cpu_wr_en;
                sel_q   <= dec_sel;
            end
            // wait_cnt holds the index of the current ACCESS cycle, zero elsewhere
            if ((state == ST_ACCESS) && (state_nxt == ST_ACCESS)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (rdata_ld) begin
                rdata_q <= rdata_nxt;
            end
            status_q <= (status_q & ~status_clr) | status_set;
            if (err_ld) begin
                err_addr_q <= err_addr_nxt;
            end
        end
    end

    assign bus.slv_addr  = addr_q;
    assign bus.slv_wdata = wdata_q;
    assign bus.slv_wr_en = ((state == ST_ACCESS) && is_wr_q)  ? sel_q : '0;
    assign bus.slv_rd_en = ((state == ST_ACCESS) && !is_wr_q) ? sel_q : '0;
    assign bus.cpu_ready = (state == ST_RESP);
    assign bus.cpu_rdata = rdata_q;
    assign err_irq       = status_q[0] | status_q[1];

endmodule

// File: tb/tb_peri_bridge.sv
// tb/tb_peri_bridge.sv - self-checking bench for peri_bridge: vector table, reset corner, random vs reference model
module tb_peri_bridge;

    localparam int TIMEOUT = 15;
    localparam logic [7:0] BASES [4] = '{8'h00, 8'h80, 8'h84, 8'h90};
    localparam logic [7:0] MASKS [4] = '{8'h80, 8'hFC, 8'hFC, 8'hFC};

    logic clk = 1'b0;
    logic reset;
    logic err_irq;
    always #5 clk = ~clk;

    peri_bridge_if #(.N_SLV(4), .DATA_W(8), .ADDR_W(8)) bus ();

    peri_bridge dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .err_irq (err_irq)
    );

    int         checks   = 0;
    int         failures = 0;
    int         lat_cfg  = 1;   // ready in this strobe cycle; 0 = never ready
    logic       noise_en = 1'b0;
    logic [7:0] sd [4];
    int         act_cnt [4];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       wr;
        logic       rd;
        int         lat;
        logic [7:0] sdata;
        logic [7:0] exp_rdata;
        int         exp_cyc;
        logic [3:0] exp_strb;
        int         exp_nstrb;
        logic       exp_irq;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // peripheral models: selected slave answers after lat_cfg strobe cycles, others may toggle ready freely
    initial begin
        bus.slv_ready = '0;
        bus.slv_rdata = '0;
        for (int i = 0; i < 4; i++) act_cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                bus.slv_rdata[i*8 +: 8] = sd[i];
                if (bus.slv_wr_en[i] || bus.slv_rd_en[i]) begin
                    act_cnt[i]++;
                    bus.slv_ready[i] = (lat_cfg != 0) && (act_cnt[i] >= lat_cfg);
                end else begin
                    act_cnt[i] = 0;
                    bus.slv_ready[i] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic run_access(input logic [7:0] addr, input logic [7:0] wdata, input logic wr, input logic rd,
                              input logic [3:0] exp_w, input logic [3:0] exp_r,
                              output logic [7:0] rdata, output int cyc, output int nstrb,
                              output int bad, output logic irq);
        cyc = 0; nstrb = 0; bad = 0;
        @(negedge clk);
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_wr_en = wr;
        bus.cpu_rd_en = rd;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.slv_wr_en != 4'b0 || bus.slv_rd_en != 4'b0) begin
                nstrb++;
                if (bus.slv_wr_en !== exp_w || bus.slv_rd_en !== exp_r || bus.slv_addr !== addr ||
                    (wr && bus.slv_wdata !== wdata)) bad++;
            end
        end while (!bus.cpu_ready && cyc < 40);
        rdata = bus.cpu_rdata;
        irq   = err_irq;
        bus.cpu_wr_en = 1'b0;
        bus.cpu_rd_en = 1'b0;
    endtask

    task automatic check_access(input string tag, input logic [7:0] addr, input logic [7:0] wdata,
                                input logic wr, input logic rd, input int lat, input logic [7:0] sdata,
                                input logic [7:0] exp_rdata, input int exp_cyc, input logic [3:0] exp_strb,
                                input int exp_nstrb, input logic exp_irq);
        logic [7:0] rdata;
        int         cyc, nstrb, bad;
        logic       irq;
        for (int i = 0; i < 4; i++) sd[i] = exp_strb[i] ? sdata : 8'($urandom);
        lat_cfg = lat;
        run_access(addr, wdata, wr, rd, wr ? exp_strb : 4'b0, wr ? 4'b0 : exp_strb,
                   rdata, cyc, nstrb, bad, irq);
        chk({tag, " latency"}, cyc, exp_cyc);
        chk({tag, " strobe cycles"}, nstrb, exp_nstrb);
        chk({tag, " bad strobe/addr/wdata cycles"}, bad, 0);
        if (!wr) chk({tag, " rdata"}, rdata, exp_rdata);
        chk({tag, " err_irq"}, irq, exp_irq);
    endtask

    // -2 status CSR, -3 err_addr CSR, -1 unmapped, else slave index
    function automatic int decode_ref(input logic [7:0] a);
        if (a == 8'hFC) return -2;
        if (a == 8'hFD) return -3;
        for (int i = 0; i < 4; i++) if ((a & MASKS[i]) == BASES[i]) return i;
        return -1;
    endfunction

    initial begin
        logic       ready_seen;
        logic [1:0] m_status;
        logic [7:0] m_erraddr;

        reset = 1'b1;
        bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_wr_en = 1'b0; bus.cpu_rd_en = 1'b0;
        for (int i = 0; i < 4; i++) sd[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset cpu_ready", bus.cpu_ready, 0);
        chk("reset cpu_rdata", bus.cpu_rdata, 0);
        chk("reset slv_addr", bus.slv_addr, 0);
        chk("reset slv_wdata", bus.slv_wdata, 0);
        chk("reset strobes", {bus.slv_wr_en, bus.slv_rd_en}, 0);
        chk("reset err_irq", err_irq, 0);
        reset = 1'b0;

        // addr, wdata, wr, rd, lat, sdata, exp_rdata, exp_cyc, exp_strb, exp_nstrb, exp_irq
        vecs[0]  = '{8'h85, 8'h00, 1'b0, 1'b1, 1,  8'h5A, 8'h5A, 2,  4'b0100, 1,  1'b0}; // 0x84-0x87 is slave 2
        vecs[1]  = '{8'h91, 8'h3C, 1'b1, 1'b0, 4,  8'h00, 8'h00, 5,  4'b1000, 4,  1'b0};
        vecs[2]  = '{8'h82, 8'h00, 1'b0, 1'b1, 15, 8'h6B, 8'h6B, 16, 4'b0010, 15, 1'b0}; // ready on last allowed cycle
        vecs[3]  = '{8'h81, 8'h00, 1'b0, 1'b1, 0,  8'h00, 8'hFF, 16, 4'b0010, 15, 1'b1}; // timeout
        vecs[4]  = '{8'hFD, 8'h00, 1'b0, 1'b1, 1,  8'h00, 8'h81, 1,  4'b0000, 0,  1'b1};
        vecs[5]  = '{8'hFC, 8'h00, 1'b0, 1'b1, 1,  8'h00, 8'h01, 1,  4'b0000, 0,  1'b1};
        vecs[6]  = '{8'hFC, 8'h01, 1'b1, 1'b0, 1,  8'h00, 8'h00, 1,  4'b0000, 0,  1'b0};
        vecs[7]  = '{8'hA0, 8'h77, 1'b1, 1'b0, 1,  8'h00, 8'h00, 1,  4'b0000, 0,  1'b1}; // unmapped write
        vecs[8]  = '{8'hFC, 8'h00, 1'b0, 1'b1, 1,  8'h00, 8'h02, 1,  4'b0000, 0,  1'b1};
        vecs[9]  = '{8'hFD, 8'h00, 1'b0, 1'b1, 1,  8'h00, 8'hA0, 1,  4'b0000, 0,  1'b1};
        vecs[10] = '{8'hFD, 8'h55, 1'b1, 1'b0, 1,  8'h00, 8'h00, 1,  4'b0000, 0,  1'b1}; // err_addr is read-only
        vecs[11] = '{8'hFD, 8'h00, 1'b0, 1'b1, 1,  8'h00, 8'hA0, 1,  4'b0000, 0,  1'b1};
        vecs[12] = '{8'hFC, 8'h02, 1'b1, 1'b0, 1,  8'h00, 8'h00, 1,  4'b0000, 0,  1'b0};
        vecs[13] = '{8'hFC, 8'h00, 1'b0, 1'b1, 1,  8'h00, 8'h00, 1,  4'b0000, 0,  1'b0};
        vecs[14] = '{8'h86, 8'h11, 1'b1, 1'b1, 2,  8'h00, 8'h00, 3,  4'b0100, 2,  1'b0}; // wr+rd -> write
        vecs[15] = '{8'h7F, 8'h00, 1'b0, 1'b1, 3,  8'h9C, 8'h9C, 4,  4'b0001, 3,  1'b0};
        vecs[16] = '{8'h8C, 8'h00, 1'b0, 1'b1, 1,  8'h00, 8'h00, 1,  4'b0000, 0,  1'b1}; // unmapped read
        vecs[17] = '{8'hFC, 8'hFF, 1'b1, 1'b0, 1,  8'h00, 8'h00, 1,  4'b0000, 0,  1'b0};
        for (int v = 0; v < 18; v++) begin
            check_access($sformatf("vec%0d", v), vecs[v].addr, vecs[v].wdata, vecs[v].wr, vecs[v].rd,
                         vecs[v].lat, vecs[v].sdata, vecs[v].exp_rdata, vecs[v].exp_cyc,
                         vecs[v].exp_strb, vecs[v].exp_nstrb, vecs[v].exp_irq);
        end

        // reset in the 3rd ACCESS cycle of a never-ready SPI read
        lat_cfg = 0;
        @(negedge clk);
        bus.cpu_addr  = 8'h81;
        bus.cpu_rd_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("mid-access strobe before reset", bus.slv_rd_en, 4'b0010);
        reset = 1'b1;
        #1;
        chk("strobes drop on reset", {bus.slv_wr_en, bus.slv_rd_en}, 0);
        ready_seen = 1'b0;
        repeat (2) @(negedge clk) if (bus.cpu_ready) ready_seen = 1'b1;
        bus.cpu_rd_en = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk) if (bus.cpu_ready) ready_seen = 1'b1;
        chk("no cpu_ready around reset", ready_seen, 0);
        chk("slv_addr cleared by reset", bus.slv_addr, 0);
        chk("err_irq cleared by reset", err_irq, 0);
        check_access("post-reset read 10", 8'h10, 8'h00, 1'b0, 1'b1, 1, 8'hC3, 8'hC3, 2, 4'b0001, 1, 1'b0);
        @(negedge clk);
        chk("cpu_rdata held in idle", bus.cpu_rdata, 8'hC3);
        check_access("write after read", 8'h92, 8'h44, 1'b1, 1'b0, 1, 8'h00, 8'h00, 2, 4'b1000, 1, 1'b0);
        chk("cpu_rdata held across write", bus.cpu_rdata, 8'hC3);

        // random traffic against a per-access reference model; unselected slaves toggle ready
        m_status  = 2'b00;
        m_erraddr = 8'h00;
        noise_en  = 1'b1;
        for (int n = 0; n < 150; n++) begin
            logic [7:0] a, wd, sdat, exp_rd;
            logic       wr, rd, is_wr;
            logic [3:0] strb;
            int         op, lat, k, cyc, nstrb;
            case ($urandom_range(0, 7))
                0:       a = 8'hFC;
                1:       a = 8'hFD;
                2:       a = 8'($urandom_range(8'h80, 8'h93));
                default: a = 8'($urandom);
            endcase
            op    = $urandom_range(0, 2);
            wr    = (op != 0);
            rd    = (op != 1);
            is_wr = wr;
            wd    = 8'($urandom);
            sdat  = 8'($urandom);
            lat   = $urandom_range(0, 6);
            k     = decode_ref(a);
            exp_rd = 8'h00; strb = 4'b0000; cyc = 1; nstrb = 0;
            if (k == -2) begin
                if (is_wr) m_status = m_status & ~wd[1:0];
                else       exp_rd = {6'b0, m_status};
            end else if (k == -3) begin
                exp_rd = m_erraddr;
            end else if (k == -1) begin
                m_status[1] = 1'b1;
                m_erraddr   = a;
            end else begin
                strb = 4'b0001 << k;
                if (lat == 0) begin
                    cyc = TIMEOUT + 1; nstrb = TIMEOUT;
                    m_status[0] = 1'b1;
                    m_erraddr   = a;
                    exp_rd      = 8'hFF;
                end else begin
                    cyc = lat + 1; nstrb = lat; exp_rd = sdat;
                end
            end
            check_access($sformatf("rnd%0d addr %0h", n, a), a, wd, wr, rd, lat, sdat,
                         exp_rd, cyc, strb, nstrb, |m_status);
        end
        noise_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
